// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: collects digits into an external digit register, hands
// complete entries to an external comparator, then holds unlocked or locked-out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ENTRY    | accepting digits; clear/submit/digit_valid in that priority
// COMPARE  | waiting for the comparator verdict (match_valid)
// UNLOCKED | lock open for UNLOCK_CYCLES or until submit relocks it
// LOCKOUT  | too many failures; all input ignored for LOCKOUT_CYCLES
module lock_sequencer #(
  parameter int MAX_DIGITS     = 10,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       system_reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       submit,
  input  logic       clear,
  input  logic [3:0] pass_len,
  input  logic       match_valid,
  input  logic       match,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       compare_start,
  output logic       clear_regs,
  output logic [3:0] entry_count,
  output logic [1:0] fail_count,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    COMPARE  = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic            overflow_q;
  logic            wr_en_q;
  logic [3:0]      wr_addr_q;
  logic [3:0]      wr_data_q;
  logic            compare_start_q;
  logic            clear_regs_q;
  logic [3:0]      entry_count_q;
  logic [1:0]      fail_count_q;
  logic            unlocked_q;
  logic            locked_out_q;

  logic [1:0]      fail_count_d;
  logic            fail_lock;
  logic            len_ok;

  assign fail_count_d = fail_count_q + 2'd1;
  assign fail_lock    = (fail_count_d == 2'(MAX_ATTEMPTS));
  assign len_ok       = (entry_count_q == pass_len) && !overflow_q && (entry_count_q != 4'd0);

  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      state_q         <= ENTRY;
      timer_q         <= '0;
      overflow_q      <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= 4'd0;
      wr_data_q       <= 4'd0;
      compare_start_q <= 1'b0;
      clear_regs_q    <= 1'b0;
      entry_count_q   <= 4'd0;
      fail_count_q    <= 2'd0;
      unlocked_q      <= 1'b0;
      locked_out_q    <= 1'b0;
    end else begin
      wr_en_q         <= 1'b0;
      compare_start_q <= 1'b0;
      clear_regs_q    <= 1'b0;

      case (state_q)
        ENTRY: begin
          if (clear) begin
            entry_count_q <= 4'd0;
            overflow_q    <= 1'b0;
            clear_regs_q  <= 1'b1;
          end else if (submit) begin
            if (len_ok) begin
              compare_start_q <= 1'b1;
              state_q         <= COMPARE;
            end else begin
              // Length mismatch fails without ever bothering the comparator.
              fail_count_q  <= fail_count_d;
              entry_count_q <= 4'd0;
              overflow_q    <= 1'b0;
              clear_regs_q  <= 1'b1;
              if (fail_lock) begin
                state_q      <= LOCKOUT;
                locked_out_q <= 1'b1;
                timer_q      <= '0;
              end
            end
          end else if (digit_valid) begin
            if (entry_count_q < 4'(MAX_DIGITS)) begin
              wr_en_q       <= 1'b1;
              wr_addr_q     <= entry_count_q;
              wr_data_q     <= digit;
              entry_count_q <= entry_count_q + 4'd1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end

        COMPARE: begin
          if (match_valid) begin
            entry_count_q <= 4'd0;
            overflow_q    <= 1'b0;
            clear_regs_q  <= 1'b1;
            timer_q       <= '0;
            if (match) begin
              fail_count_q <= 2'd0;
              state_q      <= UNLOCKED;
              unlocked_q   <= 1'b1;
            end else begin
              fail_count_q <= fail_count_d;
              if (fail_lock) begin
                state_q      <= LOCKOUT;
                locked_out_q <= 1'b1;
              end else begin
                state_q <= ENTRY;
              end
            end
          end
        end

        UNLOCKED: begin
          if (submit || (timer_q == TW'(UNLOCK_CYCLES - 1))) begin
            state_q    <= ENTRY;
            unlocked_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
            state_q      <= ENTRY;
            locked_out_q <= 1'b0;
            fail_count_q <= 2'd0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: state_q <= ENTRY;
      endcase
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign compare_start = compare_start_q;
  assign clear_regs    = clear_regs_q;
  assign entry_count   = entry_count_q;
  assign fail_count    = fail_count_q;
  assign unlocked      = unlocked_q;
  assign locked_out    = locked_out_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: hand-computed expectations for unlock,
// lockout, overflow, strobe priority and reset-during-compare scenarios.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       system_reset = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       submit = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] pass_len = 4'd4;
  logic       match_valid = 1'b0;
  logic       match = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       compare_start;
  logic       clear_regs;
  logic [3:0] entry_count;
  logic [1:0] fail_count;
  logic       unlocked;
  logic       locked_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_cmp = 0;
  int wr_addr_last = -1;
  int addr_seq_err = 0;

  lock_sequencer dut (
    .clk(clk), .system_reset(system_reset), .digit_valid(digit_valid), .digit(digit),
    .submit(submit), .clear(clear), .pass_len(pass_len), .match_valid(match_valid),
    .match(match), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .compare_start(compare_start), .clear_regs(clear_regs), .entry_count(entry_count),
    .fail_count(fail_count), .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  // Event monitor on the falling edge, well away from the output update.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      if (int'(wr_addr) != wr_addr_last + 1) addr_seq_err++;
      wr_addr_last = int'(wr_addr);
    end
    if (compare_start) n_cmp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input int d);
    digit_valid = 1'b1;
    digit = 4'(d);
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic do_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic send_match(input logic m);
    match_valid = 1'b1;
    match = m;
    tick();
    match_valid = 1'b0;
    match = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
    chk({tag, ".wr_data"}, 32'(wr_data), 0);
    chk({tag, ".compare_start"}, 32'(compare_start), 0);
    chk({tag, ".clear_regs"}, 32'(clear_regs), 0);
    chk({tag, ".entry_count"}, 32'(entry_count), 0);
    chk({tag, ".fail_count"}, 32'(fail_count), 0);
    chk({tag, ".unlocked"}, 32'(unlocked), 0);
    chk({tag, ".locked_out"}, 32'(locked_out), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, cmp0, cyc;

    // Reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    system_reset = 1'b1;
    tick();
    chk_reset_outputs("post_rst");

    // Correct 4-digit code unlocks for exactly 500 cycles
    pass_len = 4'd4;
    wr0 = n_wr; cmp0 = n_cmp; wr_addr_last = -1; addr_seq_err = 0;
    for (int i = 0; i < 4; i++) begin
      send_digit(i + 1);
      chk("ok.wr_en", 32'(wr_en), 1);
      chk("ok.wr_addr", 32'(wr_addr), 32'(i));
      chk("ok.wr_data", 32'(wr_data), 32'(i + 1));
      chk("ok.entry_count", 32'(entry_count), 32'(i + 1));
    end
    do_submit();
    chk("ok.compare_start", 32'(compare_start), 1);
    send_digit(7);
    chk("cmp.digit_ignored_wr", 32'(wr_en), 0);
    chk("cmp.digit_ignored_cnt", 32'(entry_count), 4);
    chk("cmp.start_is_pulse", 32'(compare_start), 0);
    send_match(1'b1);
    chk("ok.unlocked", 32'(unlocked), 1);
    chk("ok.clear_regs", 32'(clear_regs), 1);
    chk("ok.entry_cleared", 32'(entry_count), 0);
    chk("ok.writes", 32'(n_wr - wr0), 4);
    chk("ok.addr_seq", 32'(addr_seq_err), 0);
    chk("ok.compares", 32'(n_cmp - cmp0), 1);
    cyc = 1;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (unlocked) cyc++;
      else break;
    end
    chk("ok.unlock_cycles", 32'(cyc), 500);
    chk("ok.back_to_entry", 32'(unlocked), 0);
    send_digit(5);
    chk("ok.entry_accepts", 32'(wr_en), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr.entry_count", 32'(entry_count), 0);

    // Three short entries: failures without comparator, then lockout
    cmp0 = n_cmp;
    for (int a = 1; a <= 3; a++) begin
      for (int i = 0; i < 3; i++) send_digit(i);
      do_submit();
      chk("short.clear_regs", 32'(clear_regs), 1);
      chk("short.entry_count", 32'(entry_count), 0);
      if (a < 3) begin
        chk("short.fail_count", 32'(fail_count), 32'(a));
        chk("short.not_locked", 32'(locked_out), 0);
      end
    end
    chk("short.no_compare", 32'(n_cmp - cmp0), 0);
    chk("lock.locked_out", 32'(locked_out), 1);
    wr0 = n_wr;
    cyc = 1;
    for (int k = 0; k < 1200; k++) begin
      if (k == 10) begin digit_valid = 1'b1; submit = 1'b1; end
      if (k == 20) begin match_valid = 1'b1; match = 1'b1; end
      tick();
      digit_valid = 1'b0; submit = 1'b0; match_valid = 1'b0; match = 1'b0;
      if (locked_out) cyc++;
      else break;
    end
    chk("lock.cycles", 32'(cyc), 1000);
    chk("lock.fail_reset", 32'(fail_count), 0);
    chk("lock.strobes_ignored_wr", 32'(n_wr - wr0), 0);
    chk("lock.no_unlock", 32'(unlocked), 0);

    // 12 digits with pass_len=10: only 10 writes, submit fails
    pass_len = 4'd10;
    wr0 = n_wr; cmp0 = n_cmp; wr_addr_last = -1; addr_seq_err = 0;
    for (int i = 0; i < 12; i++) send_digit(i % 10);
    chk("ovf.entry_count", 32'(entry_count), 10);
    chk("ovf.no_write", 32'(wr_en), 0);
    chk("ovf.writes", 32'(n_wr - wr0), 10);
    chk("ovf.addr_seq", 32'(addr_seq_err), 0);
    chk("ovf.last_addr", 32'(wr_addr_last), 9);
    do_submit();
    chk("ovf.no_compare", 32'(n_cmp - cmp0), 0);
    chk("ovf.fail_count", 32'(fail_count), 1);
    chk("ovf.clear_regs", 32'(clear_regs), 1);
    chk("ovf.entry_cleared", 32'(entry_count), 0);

    // clear + submit + digit_valid together with entry_count=2
    pass_len = 4'd2;
    send_digit(3);
    send_digit(4);
    wr0 = n_wr; cmp0 = n_cmp;
    clear = 1'b1; submit = 1'b1; digit_valid = 1'b1; digit = 4'd9;
    tick();
    clear = 1'b0; submit = 1'b0; digit_valid = 1'b0;
    chk("prio.entry_count", 32'(entry_count), 0);
    chk("prio.clear_regs", 32'(clear_regs), 1);
    chk("prio.wr_en", 32'(wr_en), 0);
    chk("prio.compare_start", 32'(compare_start), 0);
    chk("prio.fail_unchanged", 32'(fail_count), 1);

    // Comparator mismatch counts a failure without lockout
    send_digit(1);
    send_digit(2);
    do_submit();
    chk("mis.compare_start", 32'(compare_start), 1);
    send_match(1'b0);
    chk("mis.fail_count", 32'(fail_count), 2);
    chk("mis.clear_regs", 32'(clear_regs), 1);
    chk("mis.not_locked", 32'(locked_out), 0);
    chk("mis.not_unlocked", 32'(unlocked), 0);

    // Reset during COMPARE, then a stale match_valid
    send_digit(1);
    send_digit(2);
    do_submit();
    chk("rc.compare_start", 32'(compare_start), 1);
    tick();
    system_reset = 1'b0;
    #1;
    chk_reset_outputs("rc.async");
    tick();
    system_reset = 1'b1;
    tick();
    send_match(1'b1);
    chk_reset_outputs("rc.after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameters (name, default, meaning): MAX_DIGITS 10, digit register depth; MAX_ATTEMPTS 3, failures before lockout; UNLOCK_CYCLES 500, unlocked hold time; LOCKOUT_CYCLES 1000, lockout duration.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 system_reset  in  1  asynchronous, active-low reset.
REQ-004 digit_valid  in  1  one-cycle strobe; digit is valid.
REQ-005 digit  in  4  entered digit value, 0-9.
REQ-006 submit  in  1  one-cycle strobe; entry complete, or relock while unlocked.
REQ-007 clear  in  1  one-cycle strobe; abandon current entry.
REQ-008 pass_len  in  4  stored password length, 1..MAX_DIGITS; sampled at submit.
REQ-009 match_valid  in  1  comparator result strobe.
REQ-010 match  in  1  comparator result; 1 = all digits equal; qualified by match_valid.
REQ-011 wr_en  out  1  digit register write strobe.
REQ-012 wr_addr  out  4  digit register index.
REQ-013 wr_data  out  4  digit to write.
REQ-014 compare_start  out  1  one-cycle pulse; start comparator.
REQ-015 clear_regs  out  1  one-cycle pulse; zero digit registers.
REQ-016 entry_count  out  4  digits accepted in current entry.
REQ-017 fail_count  out  2  consecutive failed attempts.
REQ-018 unlocked  out  1  high while in UNLOCKED.
REQ-019 locked_out  out  1  high while in LOCKOUT.

Function
REQ-020 States: ENTRY, COMPARE, UNLOCKED, LOCKOUT; all outputs registered, one-cycle latency from the causing input.
REQ-021 ENTRY, same-cycle priority: clear > submit > digit_valid; lower-priority strobes that cycle are dropped.
REQ-022 ENTRY, digit_valid with entry_count < MAX_DIGITS: next cycle wr_en=1, wr_addr=old entry_count, wr_data=digit; entry_count increments.
REQ-023 ENTRY, digit_valid with entry_count == MAX_DIGITS: no write; internal overflow flag set; entry_count holds.
REQ-024 ENTRY, clear: entry_count=0, overflow cleared, clear_regs pulses; fail_count unchanged.
REQ-025 ENTRY, submit with entry_count == pass_len, overflow clear, entry_count != 0: compare_start pulses; go to COMPARE.
REQ-026 ENTRY, submit otherwise (length mismatch): counts as a failed attempt per REQ-028 without invoking the comparator.
REQ-027 COMPARE: digit_valid, submit and clear ignored; state holds until match_valid; no timeout.
REQ-028 Failed attempt: fail_count+1; entry_count=0; clear_regs pulses; if the new count == MAX_ATTEMPTS go to LOCKOUT, else go to ENTRY.
REQ-029 COMPARE, match_valid with match=1: fail_count=0, entry_count=0, clear_regs pulses; go to UNLOCKED.
REQ-030 UNLOCKED: timer counts UNLOCK_CYCLES; on expiry or submit go to ENTRY; digit_valid and clear ignored.
REQ-031 LOCKOUT: all strobes ignored; after exactly LOCKOUT_CYCLES cycles go to ENTRY with fail_count=0.
REQ-032 match_valid outside COMPARE is ignored.
REQ-033 Timers are wide enough for their parameter and do not wrap; each timer clears on state entry.

Reset
REQ-034 system_reset low forces ENTRY immediately, including mid-COMPARE or mid-LOCKOUT; entry_count=0, fail_count=0, overflow=0, timers=0.
REQ-035 During reset: wr_en, compare_start, clear_regs, unlocked and locked_out are all 0; wr_addr=0, wr_data=0.

Verification
REQ-036 pass_len=4; digits 1,2,3,4; submit; match_valid with match=1 -> four wr_en pulses at addr 0..3, one compare_start, unlocked=1 for 500 cycles, then back to ENTRY.
REQ-037 pass_len=4; 3 digits then submit, repeated 3 times -> no compare_start, fail_count 1,2 then locked_out=1 for 1000 cycles, then fail_count=0.
REQ-038 12 digits then submit with pass_len=10 -> 10 writes only (addr 0..9), treated as failure, fail_count=1.
REQ-039 clear, submit and digit_valid in the same cycle with entry_count=2 -> entry_count=0, clear_regs pulses, no write, no compare.
REQ-040 Reset asserted during COMPARE, then match_valid after release -> state ENTRY, match ignored, all outputs at reset values.
